lfsr_seq_checker: RTL and testbench

- Downstream consumer of the 16-bit Galois LFSR pseudo-random generator.
- Accepts one 16-bit word per valid cycle, self-synchronises to the sequence, and flags and counts words that deviate from it.
- Used as the on-chip PRBS checker on the receive side of a link or memory test path.

---
 rtl/lfsr_pkg.sv | 28 ++
 rtl/lfsr_err_counter.sv | 38 +++
 rtl/lfsr_seq_checker.sv | 141 ++++++++++++++
 tb/tb_lfsr_seq_checker.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the 16-bit Galois LFSR generator/checker pair.
//   LFSR_W, DEFAULT_TAP_MASK : generator width and feedback mask
//   chk_state_t              : checker FSM states
//   lfsr_next()              : one Galois step, shared with the generator
//   popcount()               : set-bit count, used for bit-error accounting
package lfsr_pkg;
    localparam int                LFSR_W           = 16;
    localparam logic [LFSR_W-1:0] DEFAULT_TAP_MASK = 16'hB400;
    localparam int                POP_W            = $clog2(LFSR_W + 1);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } chk_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x,
                                                   input logic [LFSR_W-1:0] mask);
        return (x >> 1) ^ (x[0] ? mask : '0);
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [LFSR_W-1:0] x);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < LFSR_W; i++) n = n + POP_W'(x[i]);
        return n;
    endfunction
endpackage

// File: rtl/lfsr_err_counter.sv
// lfsr_err_counter: saturating error counter with clear priority.
//   CLK, RESET : clock, synchronous active-high reset
//   clr_i      : clear; an increment in the same cycle still lands (result = inc_i)
//   inc_en_i   : add inc_i this cycle
//   inc_i      : increment amount (1, or a popcount)
//   count_o    : current count, saturates at all-ones
module lfsr_err_counter #(
    parameter int CNT_W = 16,
    parameter int INC_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clr_i,
    input  logic             inc_en_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [CNT_W-1:0] count_o
);
    // One spare bit above the wider operand so overflow is visible before clamping.
    localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;

    logic [CNT_W-1:0] count_q, count_d, base;
    logic [SUM_W-1:0] sum;

    always_comb begin
        base    = clr_i ? '0 : count_q;
        sum     = SUM_W'(base) + SUM_W'(inc_i);
        count_d = base;
        if (inc_en_i)
            count_d = (sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : CNT_W'(sum);
    end

    always_ff @(posedge CLK) begin
        if (RESET) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: PRBS checker for the 16-bit Galois LFSR stream.
//   Self-synchronises (HUNT -> VERIFY -> LOCKED), then flywheels the expected
//   sequence and flags/counts deviating words. All outputs registered.
//   CLK, RESET : clock, synchronous active-high reset
//   in_valid   : in_word valid this cycle
//   in_word    : word from the upstream LFSR
//   clr_count  : synchronous clear of err_count
//   locked     : checker is LOCKED
//   err_pulse  : one-cycle flag per mismatching word while LOCKED
//   err_count  : saturating error count
//   expected   : word expected on the next valid cycle
// Build option: define LFSR_CHK_BITERR_EN to count bit errors (popcount of the
// difference) instead of word errors.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int          W            = LFSR_W,
    parameter logic [W-1:0] TAP_MASK    = DEFAULT_TAP_MASK,
    parameter int          LOCK_COUNT   = 4,
    parameter int          UNLOCK_COUNT = 3,
    parameter int          ERR_CNT_W    = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_word,
    input  logic                 clr_count,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [W-1:0]         expected
);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_COUNT + 1);

    chk_state_t         state_q, state_d;
    logic [W-1:0]       expected_q, expected_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic               err_inc_en;
    logic [POP_W-1:0]   err_inc;

`ifdef LFSR_CHK_BITERR_EN
    assign err_inc = popcount(in_word ^ expected_q);
`else
    assign err_inc = POP_W'(1);
`endif

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_inc_en  = 1'b0;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    // All-zero is the LFSR stuck state and can never seed a sequence.
                    if (in_word != '0) begin
                        expected_d = lfsr_next(in_word, TAP_MASK);
                        match_d    = '0;
                        state_d    = VERIFY;
                    end
                end
                VERIFY: begin
                    if (in_word == expected_q) begin
                        expected_d = lfsr_next(expected_q, TAP_MASK);
                        if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else if (in_word != '0) begin
                        expected_d = lfsr_next(in_word, TAP_MASK);
                        match_d    = '0;
                    end else begin
                        state_d = HUNT;
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: once locked, data never reseeds the generator model.
                    expected_d = lfsr_next(expected_q, TAP_MASK);
                    if (in_word == expected_q) begin
                        miss_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc_en  = 1'b1;
                        if (miss_q == MISS_W'(UNLOCK_COUNT - 1)) begin
                            state_d = HUNT;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= HUNT;
            expected_q  <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    lfsr_err_counter #(
        .CNT_W (ERR_CNT_W),
        .INC_W (POP_W)
    ) u_err_cnt (
        .CLK      (CLK),
        .RESET    (RESET),
        .clr_i    (clr_count),
        .inc_en_i (err_inc_en),
        .inc_i    (err_inc),
        .count_o  (err_count)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign expected  = expected_q;
endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb_lfsr_seq_checker: directed bench for lfsr_seq_checker.
//   u0: default parameters. u1: ERR_CNT_W=4, UNLOCK_COUNT=32 for saturation.
//   Both share the same stimulus; each phase checks the instance it targets.
//   Every injected error differs from the expected word in exactly one bit, so
//   the expectations hold with or without LFSR_CHK_BITERR_EN.
module tb_lfsr_seq_checker;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid;
    logic [15:0] in_word;
    logic        clr_count;

    logic        lk0, ep0, lk1, ep1;
    logic [15:0] ec0, ex0, ex1;
    logic [3:0]  ec1;

    int vecs = 0;
    int errs = 0;

    always #5 CLK = ~CLK;

    lfsr_seq_checker u0 (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_word(in_word),
        .clr_count(clr_count), .locked(lk0), .err_pulse(ep0),
        .err_count(ec0), .expected(ex0)
    );

    lfsr_seq_checker #(.ERR_CNT_W(4), .UNLOCK_COUNT(32)) u1 (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_word(in_word),
        .clr_count(clr_count), .locked(lk1), .err_pulse(ep1),
        .err_count(ec1), .expected(ex1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of input, then land 1 time unit after the edge.
    task automatic step(input logic v, input logic [15:0] w, input logic c);
        in_valid  = v;
        in_word   = w;
        clr_count = c;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] nxt(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    logic [15:0] e;

    initial begin
        // Reset held with a valid word present
        RESET = 1'b1; in_valid = 1'b1; in_word = 16'hACE1; clr_count = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        chk("rst_locked",   lk0, 0);
        chk("rst_err_cnt",  ec0, 0);
        chk("rst_err_pls",  ep0, 0);
        chk("rst_expected", ex0, 0);
        RESET = 1'b0;

        // Lock acquisition, back-to-back
        step(1, 16'hACE1, 0);
        chk("seed_expected", ex0, 16'hE270);
        step(1, 16'hE270, 0);
        step(1, 16'h7138, 0);
        step(1, 16'h389C, 0);
        chk("pre_lock", lk0, 0);
        step(1, 16'h1C4E, 0);
        chk("lock",          lk0, 1);
        chk("lock_expected", ex0, 16'h0E27);
        chk("lock_err_cnt",  ec0, 0);

        // Single error
        step(1, 16'h0E26, 0);
        chk("err1_pulse",    ep0, 1);
        chk("err1_cnt",      ec0, 1);
        chk("err1_locked",   lk0, 1);
        chk("err1_expected", ex0, 16'hB313);
        step(1, 16'hB313, 0);
        chk("ok_pulse",    ep0, 0);
        chk("ok_cnt",      ec0, 1);
        chk("ok_locked",   lk0, 1);
        chk("ok_expected", ex0, 16'hED89);

        // Idle cycle changes nothing
        step(0, 16'hFFFF, 0);
        chk("idle_expected", ex0, 16'hED89);
        chk("idle_pulse",    ep0, 0);

        // Loss of lock: three consecutive one-bit errors
        step(1, 16'hED88, 0);
        chk("lol1_cnt",    ec0, 2);
        chk("lol1_locked", lk0, 1);
        step(1, 16'hC2C5, 0);
        chk("lol2_cnt",    ec0, 3);
        chk("lol2_locked", lk0, 1);
        step(1, 16'h6163, 0);
        chk("lol3_cnt",      ec0, 4);
        chk("lol3_pulse",    ep0, 1);
        chk("lol3_locked",   lk0, 0);
        chk("lol3_expected", ex0, 16'h30B1);

        // Re-entry into VERIFY, reseed on mismatch, zero drops to HUNT
        step(1, 16'h1234, 0);
        chk("reseed_expected", ex0, 16'h091A);
        chk("reseed_pulse",    ep0, 0);
        step(1, 16'h091A, 0);
        chk("verify_expected", ex0, 16'h048D);
        step(1, 16'h5555, 0);
        chk("vmiss_expected", ex0, 16'h9EAA);
        chk("vmiss_cnt",      ec0, 4);
        step(1, 16'h0000, 0);
        chk("vzero_expected", ex0, 16'h9EAA);
        chk("vzero_locked",   lk0, 0);

        // Reset mid-lock (u1 never unlocked above)
        chk("u1_prerst_locked", lk1, 1);
        RESET = 1'b1;
        step(1, 16'h1C4E, 0);
        chk("midrst_locked",   lk1, 0);
        chk("midrst_cnt",      ec1, 0);
        chk("midrst_expected", ex1, 0);
        RESET = 1'b0;

        // Zero in HUNT, then gapped lock sequence
        step(1, 16'h0000, 0);
        chk("hunt_zero_expected", ex0, 0);
        step(1, 16'h0000, 0);
        step(1, 16'hACE1, 0);
        chk("hunt_seed_expected", ex0, 16'hE270);
        step(0, 16'h0000, 0);
        step(1, 16'hE270, 0);
        step(0, 16'h0000, 0);
        step(1, 16'h7138, 0);
        step(0, 16'h0000, 0);
        step(1, 16'h389C, 0);
        step(0, 16'h0000, 0);
        chk("gap_prelock", lk0, 0);
        step(1, 16'h1C4E, 0);
        chk("gap_lock",          lk0, 1);
        chk("gap_lock_expected", ex0, 16'h0E27);
        chk("gap_lock_u1",       lk1, 1);

        // Saturation on u1 (4-bit counter, unlock threshold 32)
        e = 16'h0E27;
        for (int i = 0; i < 20; i++) begin
            step(1, e ^ 16'h0001, 0);
            e = nxt(e);
            if (i == 13) chk("sat14_cnt", ec1, 14);
            if (i == 14) chk("sat15_cnt", ec1, 15);
        end
        chk("sat_cnt",      ec1, 15);
        chk("sat_locked",   lk1, 1);
        chk("sat_expected", ex1, e);

        // Clear with a simultaneous error: the increment survives
        step(1, e ^ 16'h0001, 1);
        chk("clr_err_cnt",   ec1, 1);
        chk("clr_err_pulse", ep1, 1);
        step(0, 16'h0000, 1);
        chk("clr_only_cnt", ec1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
